// File: rtl/arb_pkg.sv
// Shared definitions for the tenant packet arbiter: FSM encoding, source-field
// width and the one-hot helper used for tuser stamping.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int unsigned SRC_FIELD_W = 8;

  function automatic logic [SRC_FIELD_W-1:0] onehot8(input logic [2:0] idx);
    logic [SRC_FIELD_W-1:0] oh;
    oh = 8'h01 << idx;
    return oh;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first requester after last_ptr, wrapping at
// NUM_PORTS with an explicit compare so non-power-of-2 port counts work.
module rr_select #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_ptr,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic                 gnt_vld
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = last_ptr;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (cand == IDX_W'(NUM_PORTS - 1)) begin
        cand = '0;
      end else begin
        cand = cand + IDX_W'(1);
      end
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

endmodule

// File: rtl/tenant_pkt_arbiter.sv
// Packet-level round-robin arbiter feeding one AXI-Stream processing pipeline
// from NUM_PORTS tenant streams; stamps the source port into tuser and counts packets.
module tenant_pkt_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS            = 4,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned SRC_FIELD_LSB        = 16,
  parameter int unsigned STAMP_SRC            = 1,
  parameter int unsigned CNT_WIDTH            = 32
) (
  input  logic                                   CLK_156,
  input  logic                                   ARESETN_156,
  input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
  input  logic [NUM_PORTS-1:0]                   s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                   s_axis_tlast,
  output logic [NUM_PORTS-1:0]                   s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]       m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]        m_axis_tuser,
  output logic                                   m_axis_tvalid,
  output logic                                   m_axis_tlast,
  input  logic                                   m_axis_tready,
  input  logic [NUM_PORTS-1:0]                   port_en,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]         pkt_cnt
);

  localparam int unsigned DW    = C_S_AXIS_DATA_WIDTH;
  localparam int unsigned KW    = C_S_AXIS_DATA_WIDTH / 8;
  localparam int unsigned TUW   = C_S_AXIS_TUSER_WIDTH;
  localparam int unsigned IDX_W = $clog2(NUM_PORTS);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     last_ptr_q, last_ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_PORTS];

  logic [NUM_PORTS-1:0] req;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_vld;
  logic                 busy;
  logic                 xfer;
  logic                 pkt_done;

  assign req      = s_axis_tvalid & port_en;
  assign busy     = (state_q == BUSY);
  assign xfer     = busy & s_axis_tvalid[grant_q] & m_axis_tready;
  assign pkt_done = xfer & s_axis_tlast[grant_q];

  rr_select #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_select (
    .req      (req),
    .last_ptr (last_ptr_q),
    .gnt_idx  (pick_idx),
    .gnt_vld  (pick_vld)
  );

  // Output mux follows the held grant; valid/ready are gated so IDLE moves nothing.
  always_comb begin
    m_axis_tdata  = s_axis_tdata[grant_q*DW +: DW];
    m_axis_tkeep  = s_axis_tkeep[grant_q*KW +: KW];
    m_axis_tuser  = s_axis_tuser[grant_q*TUW +: TUW];
    m_axis_tvalid = busy & s_axis_tvalid[grant_q];
    m_axis_tlast  = busy & s_axis_tlast[grant_q];
    s_axis_tready = '0;
    if (STAMP_SRC != 0) begin
      m_axis_tuser[SRC_FIELD_LSB +: SRC_FIELD_W] = onehot8(3'(grant_q));
    end
    if (busy) begin
      s_axis_tready[grant_q] = m_axis_tready;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_ptr_d = last_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (pkt_done) begin
          last_ptr_d = grant_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_156 or negedge ARESETN_156) begin
    if (!ARESETN_156) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_ptr_q <= IDX_W'(NUM_PORTS - 1);
      for (int i = 0; i < NUM_PORTS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_ptr_q <= last_ptr_d;
      if (pkt_done) begin
        cnt_q[grant_q] <= cnt_q[grant_q] + CNT_WIDTH'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt_out
    assign pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
  end

endmodule

// File: tb/tb_tenant_pkt_arbiter.sv
// Directed bench for tenant_pkt_arbiter: per-port source queues drive stimulus,
// expected beats go into a scoreboard queue that a negedge monitor pops and checks.
module tb_tenant_pkt_arbiter;

  localparam int NP = 4;
  localparam int DW = 256;
  localparam int KW = DW / 8;
  localparam int UW = 128;
  localparam int CW = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NP*DW-1:0]  s_tdata;
  logic [NP*KW-1:0]  s_tkeep;
  logic [NP*UW-1:0]  s_tuser;
  logic [NP-1:0]     s_tvalid;
  logic [NP-1:0]     s_tlast;
  logic [NP-1:0]     s_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic [UW-1:0]     m_tuser;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready;
  logic [NP-1:0]     port_en;
  logic [NP*CW-1:0]  pkt_cnt;

  always #5 clk = ~clk;

  tenant_pkt_arbiter #(
    .NUM_PORTS            (NP),
    .C_S_AXIS_DATA_WIDTH  (DW),
    .C_S_AXIS_TUSER_WIDTH (UW),
    .SRC_FIELD_LSB        (16),
    .STAMP_SRC            (1),
    .CNT_WIDTH            (CW)
  ) dut (
    .CLK_156       (clk),
    .ARESETN_156   (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .port_en       (port_en),
    .pkt_cnt       (pkt_cnt)
  );

  typedef struct packed {
    logic          idle;
    logic          last;
    logic [DW-1:0] data;
    logic [UW-1:0] user;
  } beat_t;

  typedef struct packed {
    logic [1:0]    port;
    logic          last;
    logic [DW-1:0] data;
    logic [UW-1:0] user;
  } exp_t;

  beat_t       src_q [NP][$];
  exp_t        exp_q [$];
  int unsigned exp_cnt [NP];
  int          n_chk = 0;
  int          n_fail = 0;
  logic        tight = 1'b0;
  logic        toggle_rdy = 1'b0;
  logic [NP-1:0] fire;

  // Monitor-private state
  logic          mid_pkt = 1'b0;
  logic          seen_last = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  int            idle_run = 0;
  exp_t          e;
  logic [NP-1:0] er;

  function automatic logic [DW-1:0] beat_data(input int p, input int id, input int b);
    return {8{32'(p * 32'h0100_0000 + id * 32'h100 + b)}};
  endfunction

  function automatic logic [UW-1:0] user_in(input int p, input int id);
    return {32'h1234_5678, 32'(id), 32'(p), 8'h00, 8'hA5, 16'hBEEF};
  endfunction

  function automatic logic [UW-1:0] user_exp(input int p, input int id);
    logic [UW-1:0] u;
    logic [7:0]    oh;
    u  = user_in(p, id);
    oh = 8'h01;
    oh = oh << p;
    u[23:16] = oh;
    return u;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic src_pkt(input int p, input int id, input int nb,
                         input int gap_after = -1, input int gap_len = 0);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      b = '{idle: 1'b0, last: (i == nb - 1), data: beat_data(p, id, i), user: user_in(p, id)};
      src_q[p].push_back(b);
      if (i == gap_after) begin
        for (int k = 0; k < gap_len; k++) begin
          b = '{idle: 1'b1, last: 1'b0, data: '0, user: '0};
          src_q[p].push_back(b);
        end
      end
    end
  endtask

  task automatic exp_pkt(input int p, input int id, input int nb);
    exp_t x;
    for (int i = 0; i < nb; i++) begin
      x = '{port: 2'(p), last: (i == nb - 1), data: beat_data(p, id, i), user: user_exp(p, id)};
      exp_q.push_back(x);
    end
    exp_cnt[p]++;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: %0d beats outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #2;
  endtask

  task automatic wait_level(input string name, input int level);
    int n = 0;
    while (exp_q.size() > level && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > level) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: %0d beats outstanding, expected <= %0d", name, exp_q.size(),
               level);
    end
  endtask

  task automatic check_cnts(input string name);
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("%s_pkt_cnt%0d", name, p), pkt_cnt[p*CW +: CW], exp_cnt[p]);
    end
  endtask

  task automatic assert_reset(input string name);
    rst_n = 1'b0;
    #1;
    chk({name, "_tvalid"}, m_tvalid, 0);
    chk({name, "_tready"}, s_tready, 0);
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("%s_pkt_cnt%0d", name, p), pkt_cnt[p*CW +: CW], 0);
      exp_cnt[p] = 0;
      src_q[p].delete();
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  // Source driver: pops on a handshake seen at the preceding negedge, drives after posedge.
  initial begin
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    s_tuser  = '0;
    s_tkeep  = '1;
    m_tready = 1'b1;
    forever begin
      @(negedge clk);
      fire = s_tvalid & s_tready;
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (src_q[p].size() != 0 && (src_q[p][0].idle || fire[p])) begin
          void'(src_q[p].pop_front());
        end
        if (src_q[p].size() != 0 && !src_q[p][0].idle) begin
          s_tvalid[p]            = 1'b1;
          s_tlast[p]             = src_q[p][0].last;
          s_tdata[p*DW +: DW]    = src_q[p][0].data;
          s_tuser[p*UW +: UW]    = src_q[p][0].user;
        end else begin
          s_tvalid[p] = 1'b0;
          s_tlast[p]  = 1'b0;
        end
      end
      m_tready = toggle_rdy ? ~m_tready : 1'b1;
    end
  end

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mid_pkt    = 1'b0;
        seen_last  = 1'b0;
        prev_stall = 1'b0;
        idle_run   = 0;
      end else if (m_tvalid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %0h with no beat expected", m_tdata);
        end else begin
          e  = exp_q[0];
          er = '0;
          er[e.port] = m_tready;
          chk("tready_vec", s_tready, er);
          if (prev_stall) chk("stall_hold", m_tdata, prev_data);
          if (m_tready) begin
            void'(exp_q.pop_front());
            chk("beat_data", m_tdata, e.data);
            chk("beat_last", m_tlast, e.last);
            chk("beat_user", m_tuser, e.user);
            chk("beat_keep", m_tkeep, {KW{1'b1}});
            if (!mid_pkt && tight && seen_last) chk("bubble_len", idle_run, 1);
            mid_pkt  = !e.last;
            if (e.last) seen_last = 1'b1;
            idle_run = 0;
          end
          prev_stall = !m_tready;
          prev_data  = m_tdata;
        end
      end else begin
        prev_stall = 1'b0;
        idle_run++;
        if (!mid_pkt) chk("idle_tready", s_tready, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    port_en = 4'b1111;
    for (int p = 0; p < NP; p++) exp_cnt[p] = 0;
    #2;
    chk("por_tvalid", m_tvalid, 0);
    chk("por_tready", s_tready, 0);
    @(posedge clk);
    #3;
    assert_reset("init");

    // Single 3-beat packet on port 0: one bubble cycle, then beats with src field 01
    src_pkt(0, 0, 3);
    exp_pkt(0, 0, 3);
    @(posedge clk);
    #3;
    chk("t1_bubble_tvalid", m_tvalid, 0);
    @(posedge clk);
    #3;
    chk("t1_first_tvalid", m_tvalid, 1);
    chk("t1_src_field", m_tuser[23:16], 8'h01);
    wait_drain("t1", 50);
    check_cnts("t1");

    // All ports busy, 2-beat packets: order 0,1,2,3,0,1,2,3 with single bubbles
    @(posedge clk);
    #3;
    assert_reset("t2rst");
    tight = 1'b1;
    for (int id = 0; id < 2; id++) begin
      for (int p = 0; p < NP; p++) src_pkt(p, id, 2);
    end
    for (int id = 0; id < 2; id++) begin
      for (int p = 0; p < NP; p++) exp_pkt(p, id, 2);
    end
    wait_drain("t2", 100);
    tight = 1'b0;
    check_cnts("t2");

    // port_en=1011: order 0,1,3,0; enabling port 2 mid-packet of port 1 grants 2 next
    port_en = 4'b1011;
    src_pkt(0, 0, 2);
    src_pkt(0, 1, 2);
    src_pkt(1, 0, 2);
    src_pkt(2, 0, 2);
    src_pkt(3, 0, 2);
    exp_pkt(0, 0, 2);
    exp_pkt(1, 0, 2);
    exp_pkt(3, 0, 2);
    exp_pkt(0, 1, 2);
    wait_drain("t3a", 100);
    src_pkt(1, 1, 4);
    exp_pkt(1, 1, 4);
    exp_pkt(2, 0, 2);
    wait_level("t3b", 5);
    #2;
    port_en = 4'b1111;
    wait_drain("t3b", 100);
    check_cnts("t3");

    // Toggling m_axis_tready during a 4-beat packet on port 3, port 0 waiting
    toggle_rdy = 1'b1;
    src_pkt(3, 0, 4);
    src_pkt(0, 2, 2);
    exp_pkt(3, 0, 4);
    exp_pkt(0, 2, 2);
    wait_drain("t4", 100);
    toggle_rdy = 1'b0;
    check_cnts("t4");

    // Port 1 drops tvalid for 5 cycles mid-packet while port 2 waits
    src_pkt(1, 2, 4, 1, 5);
    src_pkt(2, 1, 2);
    exp_pkt(1, 2, 4);
    exp_pkt(2, 1, 2);
    wait_level("t5", 4);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #3;
      chk($sformatf("t5_gap_hold%0d", k), s_tready, 4'b0010);
    end
    wait_drain("t5", 100);
    check_cnts("t5");

    // Reset mid-packet on port 1, then arbitration restarts at port 0
    src_pkt(1, 3, 6);
    exp_pkt(1, 3, 6);
    wait_level("t6", 4);
    @(posedge clk);
    #3;
    chk("t6_pre_reset_tvalid", m_tvalid, 1);
    assert_reset("t6rst");
    for (int p = 0; p < NP; p++) src_pkt(p, 4, 1);
    for (int p = 0; p < NP; p++) exp_pkt(p, 4, 1);
    wait_drain("t6", 100);
    check_cnts("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
